// File: rtl/sram_1r1w_pipe.sv
// sram_1r1w_pipe: behavioural 1-read/1-write SRAM with bit-masked writes,
// a configurable read latency and a configurable read-during-write policy.
// Optional macro SRAM_INIT_CLEAR_EN adds a zero-fill sweep after every reset;
// while the sweep runs busy_out is high and port requests are ignored.
// Without the macro busy_out is tied low and the array starts uninitialised.
module sram_1r1w_pipe #(
  parameter int BITS               = 64,
  parameter int WORD_DEPTH         = 16384,
  parameter int ADDR_WIDTH         = 14,
  parameter int READ_LATENCY       = 1,
  parameter int RDW_MODE           = 0,
  parameter int corrupt_mem_on_X_p = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_ce_in,
  input  logic [ADDR_WIDTH-1:0] rd_addr_in,
  output logic [BITS-1:0]       rd_out,
  output logic                  rd_valid_out,
  input  logic                  wr_ce_in,
  input  logic [ADDR_WIDTH-1:0] wr_addr_in,
  input  logic [BITS-1:0]       wd_in,
  input  logic [BITS-1:0]       w_mask_in,
  output logic                  busy_out
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH+1)'(WORD_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_DEPTH - 1);

  logic [BITS-1:0] mem [0:WORD_DEPTH-1];

  logic                  busy;
  logic                  clear_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  x_hit;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  rd_in_range;
  logic                  wr_in_range;
  logic [BITS-1:0]       rd_word;
  logic [BITS-1:0]       rd_data;
  logic [BITS-1:0]       wr_merged;

  // Read pipeline: stage 0 is the registered array read, last stage drives rd_out.
  logic                  pipe_valid [0:READ_LATENCY-1];
  logic [BITS-1:0]       pipe_data  [0:READ_LATENCY-1];

`ifdef SRAM_INIT_CLEAR_EN
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t                state_reg;
  logic [ADDR_WIDTH-1:0] clr_addr_reg;
  logic                  busy_reg;

  // Zero-fill sweep: reset (re)starts at word 0, the last word returns to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= CLEAR;
      clr_addr_reg <= '0;
      busy_reg     <= 1'b1;
    end else begin
      case (state_reg)
        CLEAR: begin
          clr_addr_reg <= clr_addr_reg + 1'b1;
          if (clr_addr_reg == LAST_ADDR) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_reg;
  assign clear_we = (state_reg == CLEAR);
  assign clr_addr = clr_addr_reg;
`else
  assign busy     = 1'b0;
  assign clear_we = 1'b0;
  assign clr_addr = '0;
`endif

  assign busy_out = busy;

  // Requests are only honoured outside reset and while the array is available.
  assign rd_acc      = rd_ce_in && !busy && !rst;
  assign wr_acc      = wr_ce_in && !busy && !rst;
  assign rd_in_range = ({1'b0, rd_addr_in} < DEPTH_W);
  assign wr_in_range = ({1'b0, wr_addr_in} < DEPTH_W);

`ifndef SYNTHESIS
  // Simulation-only detection of unknown control/address values.
  always_comb begin
    x_hit = 1'b0;
    if (corrupt_mem_on_X_p != 0) begin
      x_hit = $isunknown(rd_ce_in) || $isunknown(wr_ce_in) ||
              ((rd_ce_in === 1'b1) && $isunknown(rd_addr_in)) ||
              ((wr_ce_in === 1'b1) && $isunknown(wr_addr_in));
    end
  end
`else
  assign x_hit = 1'b0;
`endif

  // Read word selection: out-of-range reads return 0, same-address collisions
  // return either the stored word or the merged write word.
  always_comb begin
    rd_word   = rd_in_range ? mem[rd_addr_in] : '0;
    wr_merged = (wd_in & w_mask_in) | (mem[wr_addr_in] & ~w_mask_in);
    rd_data   = rd_word;
    if ((RDW_MODE == 1) && wr_acc && wr_in_range && rd_in_range &&
        (rd_addr_in == wr_addr_in)) begin
      rd_data = (wd_in & w_mask_in) | (rd_word & ~w_mask_in);
    end
    if (x_hit) begin
      rd_data = 'x;
    end
  end

  // Array write port: sweep writes take priority, user writes are bit-merged.
  always_ff @(posedge clk) begin
`ifndef SYNTHESIS
    if (x_hit) begin
      $warning("sram_1r1w_pipe: X on control/address input, array corrupted");
      for (int i = 0; i < WORD_DEPTH; i++) begin
        mem[i] <= 'x;
      end
    end else
`endif
    if (clear_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_acc && wr_in_range) begin
      mem[wr_addr_in] <= wr_merged;
    end
  end

  // Read pipeline: data only advances with a valid token so rd_out holds between results.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_data[i]  <= '0;
      end
    end else begin
      pipe_valid[0] <= rd_acc;
      if (rd_acc) begin
        pipe_data[0] <= rd_data;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        if (pipe_valid[i-1]) begin
          pipe_data[i] <= pipe_data[i-1];
        end
      end
    end
  end

  assign rd_out       = pipe_data[READ_LATENCY-1];
  assign rd_valid_out = pipe_valid[READ_LATENCY-1];

endmodule

// File: tb/tb_sram_1r1w_pipe.sv
// Testbench for sram_1r1w_pipe: two instances (latency 1 / old-data and
// latency 3 / new-data) share one randomized stimulus stream and are checked
// against a word-level memory model with per-instance expected-result queues.
module tb_sram_1r1w_pipe;

  localparam int BITS  = 64;
  localparam int DEPTH = 12;
  localparam int AW    = 4;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic          clk;
  logic          rst;
  logic          rd_ce;
  logic [AW-1:0] rd_addr;
  logic          wr_ce;
  logic [AW-1:0] wr_addr;
  logic [63:0]   wd;
  logic [63:0]   wmask;

  logic [63:0]   rd_out_a, rd_out_b;
  logic          rd_valid_a, rd_valid_b;
  logic          busy_a, busy_b;

  sram_1r1w_pipe #(
    .BITS(BITS), .WORD_DEPTH(DEPTH), .ADDR_WIDTH(AW),
    .READ_LATENCY(LAT_A), .RDW_MODE(0), .corrupt_mem_on_X_p(1)
  ) u_dut_a (
    .clk(clk), .rst(rst),
    .rd_ce_in(rd_ce), .rd_addr_in(rd_addr),
    .rd_out(rd_out_a), .rd_valid_out(rd_valid_a),
    .wr_ce_in(wr_ce), .wr_addr_in(wr_addr),
    .wd_in(wd), .w_mask_in(wmask),
    .busy_out(busy_a)
  );

  sram_1r1w_pipe #(
    .BITS(BITS), .WORD_DEPTH(DEPTH), .ADDR_WIDTH(AW),
    .READ_LATENCY(LAT_B), .RDW_MODE(1), .corrupt_mem_on_X_p(1)
  ) u_dut_b (
    .clk(clk), .rst(rst),
    .rd_ce_in(rd_ce), .rd_addr_in(rd_addr),
    .rd_out(rd_out_b), .rd_valid_out(rd_valid_b),
    .wr_ce_in(wr_ce), .wr_addr_in(wr_addr),
    .wd_in(wd), .w_mask_in(wmask),
    .busy_out(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [63:0] data;
  } exp_t;

  logic [63:0] model_mem [0:DEPTH-1];
  exp_t        q_a [$];
  exp_t        q_b [$];
  logic [63:0] last_a, last_b;
  int          busy_cnt;
  int          edge_no;
  int          n_checks;
  int          n_errors;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (edge %0d)", tag, got, exp, edge_no);
    end
  endtask

  // Predict the effect of the coming edge, take it, then compare outputs.
  task automatic do_edge();
    logic [63:0] old_w, new_w, cur;
    exp_t        e;
    if (rst) begin
      q_a.delete();
      q_b.delete();
      last_a = '0;
      last_b = '0;
`ifdef SRAM_INIT_CLEAR_EN
      busy_cnt = DEPTH;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
`else
      busy_cnt = 0;
`endif
    end else begin
      if (busy_cnt == 0) begin
        if (rd_ce) begin
          old_w = (int'(rd_addr) < DEPTH) ? model_mem[rd_addr] : 64'h0;
          new_w = old_w;
          if (wr_ce && (wr_addr == rd_addr) && (int'(rd_addr) < DEPTH))
            new_w = (wd & wmask) | (old_w & ~wmask);
          e.due = edge_no + LAT_A - 1; e.data = old_w; q_a.push_back(e);
          e.due = edge_no + LAT_B - 1; e.data = new_w; q_b.push_back(e);
        end
        if (wr_ce && (int'(wr_addr) < DEPTH)) begin
          cur = model_mem[wr_addr];
          model_mem[wr_addr] = (wd & wmask) | (cur & ~wmask);
        end
      end else begin
        busy_cnt--;
      end
    end
    @(posedge clk);
    #1;
    check_value("busy_a", {63'b0, busy_a}, {63'b0, busy_cnt != 0});
    check_value("busy_b", {63'b0, busy_b}, {63'b0, busy_cnt != 0});
    if (q_a.size() > 0 && q_a[0].due == edge_no) begin
      check_value("valid_a", {63'b0, rd_valid_a}, 64'd1);
      check_value("data_a", rd_out_a, q_a[0].data);
      last_a = q_a[0].data;
      void'(q_a.pop_front());
    end else begin
      check_value("idle_valid_a", {63'b0, rd_valid_a}, 64'd0);
      check_value("hold_a", rd_out_a, last_a);
    end
    if (q_b.size() > 0 && q_b[0].due == edge_no) begin
      check_value("valid_b", {63'b0, rd_valid_b}, 64'd1);
      check_value("data_b", rd_out_b, q_b[0].data);
      last_b = q_b[0].data;
      void'(q_b.pop_front());
    end else begin
      check_value("idle_valid_b", {63'b0, rd_valid_b}, 64'd0);
      check_value("hold_b", rd_out_b, last_b);
    end
    edge_no++;
  endtask

  task automatic access(input logic r_ce, input logic [AW-1:0] r_a,
                        input logic w_ce, input logic [AW-1:0] w_a,
                        input logic [63:0] d, input logic [63:0] m);
    rd_ce = r_ce; rd_addr = r_a; wr_ce = w_ce; wr_addr = w_a; wd = d; wmask = m;
    do_edge();
    $display("edge %0d: rd=%0b@%0d wr=%0b@%0d wd=%h mask=%h", edge_no - 1, r_ce, r_a, w_ce, w_a, d, m);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) access(1'b0, '0, 1'b0, '0, '0, '0);
  endtask

  task automatic wait_ready();
    int guard;
    guard = 0;
    while (busy_cnt != 0 && guard < 4 * DEPTH) begin
      idle(1);
      guard++;
    end
  endtask

  initial begin
    n_checks = 0; n_errors = 0; edge_no = 0; busy_cnt = 0;
    last_a = '0; last_b = '0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    rst = 1'b1; rd_ce = 1'b0; rd_addr = '0; wr_ce = 1'b0; wr_addr = '0; wd = '0; wmask = '0;
    idle(2);
    rst = 1'b0;

`ifdef SRAM_INIT_CLEAR_EN
    // Reads issued while the sweep runs must be ignored.
    for (int i = 0; i < DEPTH; i++) access(1'b1, AW'(i), 1'b1, AW'(i), 64'hA5A5, '1);
    wait_ready();
    for (int i = 0; i < DEPTH; i++) access(1'b1, AW'(i), 1'b0, '0, '0, '0);
`else
    for (int i = 0; i < DEPTH; i++) access(1'b0, '0, 1'b1, AW'(i), {$urandom, $urandom}, '1);
`endif
    idle(4);

    // Full-word write then read.
    access(1'b0, '0, 1'b1, 4'd5, 64'hDEAD_BEEF_0123_4567, '1);
    access(1'b1, 4'd5, 1'b0, '0, '0, '0);
    idle(4);

    // Masked write keeps the unmasked upper byte.
    access(1'b0, '0, 1'b1, 4'd3, '1, '1);
    access(1'b0, '0, 1'b1, 4'd3, '0, 64'h00FF_FFFF_FFFF_FFFF);
    access(1'b1, 4'd3, 1'b0, '0, '0, '0);
    access(1'b0, '0, 1'b1, 4'd3, 64'h1234, '0);
    access(1'b1, 4'd3, 1'b0, '0, '0, '0);
    idle(4);

    // Same-cycle read and write of addr 9.
    access(1'b0, '0, 1'b1, 4'd9, 64'h1, '1);
    access(1'b1, 4'd9, 1'b1, 4'd9, 64'h2, '1);
    access(1'b1, 4'd9, 1'b0, '0, '0, '0);
    idle(4);

    // Back-to-back reads, then reset while reads are in flight.
    access(1'b1, 4'd0, 1'b0, '0, '0, '0);
    access(1'b1, 4'd1, 1'b0, '0, '0, '0);
    access(1'b1, 4'd2, 1'b0, '0, '0, '0);
    idle(4);
    access(1'b1, 4'd4, 1'b0, '0, '0, '0);
    rst = 1'b1;
    access(1'b1, 4'd5, 1'b0, '0, '0, '0);
    rst = 1'b0;
    idle(4);
    wait_ready();

    // Out-of-range write is discarded, read returns zero.
    access(1'b0, '0, 1'b1, 4'd13, '1, '1);
    access(1'b1, 4'd13, 1'b0, '0, '0, '0);
    for (int i = 0; i < DEPTH; i++) access(1'b1, AW'(i), 1'b0, '0, '0, '0);
    idle(4);

    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      access($urandom_range(0, 2) != 0, AW'($urandom_range(0, 15)),
             $urandom_range(0, 1) == 1, AW'($urandom_range(0, 15)),
             {$urandom, $urandom},
             ($urandom_range(0, 1) == 1) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom});
      rst = 1'b0;
    end
    idle(6);
    wait_ready();
    check_value("queue_a_drained", 64'(q_a.size()), 64'd0);
    check_value("queue_b_drained", 64'(q_b.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
